// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state encoding and width bounds for the serial adder controller
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_ADD  = ST_ADD,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell shared by the serial adder
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder, LSB first; SERIAL_ADDER_SUB_EN adds a subtract port
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH out of legal range");
   end

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
   logic [WIDTH-1:0] b_load;
   logic             carry, carry_load;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             fa_sum, fa_cout;

   // Subtraction is a + ~b + 1, so only the loaded B operand and initial carry differ.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = sub ? ~op_b : op_b;
   assign carry_load = sub | cin;
`else
   assign b_load     = op_b;
   assign carry_load = cin;
`endif

   assign last_bit = (cnt == CW'(WIDTH - 1));

   fulladder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Result shifts in from the MSB so the LSB lands at bit 0 after WIDTH steps.
   always_comb begin
      res_nx            = res_sh >> 1;
      res_nx[WIDTH-1]   = fa_sum;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state: accept in IDLE, one bit per cycle in ADD, single-cycle DONE.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_ADD;
         S_ADD:   if (last_bit) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand/result shifting, carry chaining and result capture on the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh  <= op_a;
                  b_sh  <= b_load;
                  carry <= carry_load;
                  cnt   <= '0;
               end
            end
            S_ADD: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_nx;
               carry  <= fa_cout;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  sum  <= res_nx;
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder built around one shared 1-bit fulladder cell. The controller latches two WIDTH-bit operands, feeds the cell one bit pair per clock (LSB first), and registers the carry between bits. It assembles the sum in a shift register and returns the result through a start/busy/done handshake. Intended as the area-minimal adder option beside the ripple adders in the adder library.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_a  input  WIDTH  operand A, sampled on the accepting edge
op_b  input  WIDTH  operand B, sampled on the accepting edge
cin  input  1  carry-in of the whole addition, sampled on the accepting edge
busy  output  1  high in ADD and DONE states
done  output  1  one-cycle completion pulse
sum  output  WIDTH  registered result; holds the last completed value
cout  output  1  registered carry-out of the last completed addition

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry register=0, operand/shift registers=0.
- States: IDLE, ADD, DONE. Registered Moore outputs: busy=(state!=IDLE), done=(state==DONE).
- IDLE: on an edge with start=1, latch op_a/op_b into shift registers, carry<=cin, cnt<=0, go to ADD. With start=0, stay.
- ADD, one bit per edge:
  - fulladder inputs: a=a_sh[0], b=b_sh[0], cin=carry.
  - Shift a_sh/b_sh right one bit.
  - Shift the cell's sum into res_sh at the MSB (shift right).
  - carry<=cout of the cell; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: load sum<=final res_sh value and cout<=cell cout, then go to DONE.
- DONE: lasts exactly one cycle; done=1; unconditional return to IDLE.
- Latency: start accepted on edge E0. Bits are processed on E1..E_WIDTH. done is high for the cycle following E_WIDTH. Throughput is one result per WIDTH+2 cycles; back-to-back start is accepted on the edge leaving DONE's following IDLE cycle.
- start during ADD or DONE is ignored, not queued. Operand changes after acceptance have no effect.
- sum/cout change only on the completing edge and hold until the next completion or reset.
- Counter width: $clog2(WIDTH)+1. WIDTH=1 works: one ADD cycle, then DONE.
- Reset asserted mid-operation aborts immediately: all state and outputs clear; no done pulse; the previous sum is lost (reads 0).

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined: adds input port sub (1 bit, sampled with start). When sub=1, the controller latches ~op_b and forces the initial carry to 1 (cin ignored), computing op_a-op_b in two's complement. cout=1 means no borrow.
- Undefined: no sub port; addition only, using cin as given.

Decomposition:
- Package serial_adder_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2;
  - WIDTH legal-range bounds used by an elaboration check.
- Exactly one sub-module: the existing fulladder (ports a, b, cin, sum, cout), instantiated once.
- No other hierarchy.

Test Plan:
1. WIDTH=8; op_a=8'hFF, op_b=8'h01, cin=0, start pulse -> done on the 9th edge after acceptance; sum=8'h00, cout=1; busy high for 9 cycles.
2. op_a=8'h5A, op_b=8'hA5, cin=1 -> sum=8'h00, cout=1. Then op_a=8'h12, op_b=8'h34, cin=0 -> sum=8'h46, cout=0. sum holds 8'h00 throughout the second operation until its done.
3. start held high continuously, operands changed every cycle during ADD -> exactly one done per WIDTH+2 cycles; each result matches the operands latched at that operation's acceptance edge.
4. rst_n pulsed low at bit 4 of 8'hF0+8'h0F -> busy=0, done=0, sum=0, cout=0 immediately. No done pulse afterwards; the next start completes normally.
5. WIDTH=1; op_a=1, op_b=1, cin=1 -> sum=1, cout=1, done one edge after the single ADD cycle.
6. With SERIAL_ADDER_SUB_EN: sub=1, 8'h10-8'h01 -> sum=8'h0F, cout=1; sub=1, 8'h03-8'h05 -> sum=8'hFE, cout=0.
